goofy_fetch: RTL and testbench
==============================

Name: goofy_fetch

Overview:
Instruction fetch stage sitting directly upstream of the GoofyCore decode/microcode sequencer. It reads 3-byte instructions (iop, op0, op1) from a byte-wide memory port using a req/ack handshake and presents each complete instruction with a valid/ready handshake. It also owns the instruction pointer (rip), accepts jump redirects from the core and stops fetching on halt.

Parameters:
ADDR_W, 8, width of rip and memory address; arithmetic is modulo 2^ADDR_W.
DATA_W, 8, memory data width and width of each instruction byte.
RESET_VEC, 0, rip value after reset.

Ports:
clk  in  1  system clock; all state updates on the rising edge.
res  in  1  reset; asynchronous, active-low (res=0 resets).
mem_req  out  1  memory read request.
mem_addr  out  ADDR_W  read address; stable while mem_req=1.
mem_ack  in  1  read complete; mem_data is valid in the same cycle.
mem_data  in  DATA_W  read data.
ins_valid  out  1  iop/op0/op1/ins_rip hold a complete instruction.
ins_ready  in  1  core accepts the instruction.
iop  out  DATA_W  opcode byte.
op0  out  DATA_W  operand byte 0.
op1  out  DATA_W  operand byte 1.
ins_rip  out  ADDR_W  address of the presented opcode byte.
jmp_en  in  1  redirect request.
jmp_addr  in  ADDR_W  redirect target.
hlt  in  1  core halt indication; sticky inside this block.
halted  out  1  fetch stopped.

Behaviour:
- States: F_OP, F_A, F_B, VALID, HALTED.
- Reset (res=0, any time, including mid-fetch): state=F_OP, rip=RESET_VEC, iop/op0/op1=0, ins_rip=0, ins_valid=0, halted=0. mem_req=1 and mem_addr=RESET_VEC in the first cycle after release.
- F_OP/F_A/F_B:
  - mem_req=1; mem_addr = rip, rip+1, rip+2 respectively, each wrapping modulo 2^ADDR_W.
  - On mem_ack, capture mem_data into iop/op0/op1 respectively and advance one state. F_B advances to VALID.
  - Without mem_ack, stay in the state; the address is held.
- VALID:
  - ins_valid=1; mem_req=0; outputs stable until the handshake.
  - On ins_valid&&ins_ready: rip <= rip+3 (wrapping), next state F_OP.
- ins_rip latches rip on entry to VALID.
- Minimum latency with zero-wait memory: req cycles 0,1,2; ins_valid in cycle 3; 4 cycles per instruction. No prefetch.
- Jump (jmp_en=1, any non-HALTED state):
  - rip <= jmp_addr; next state F_OP; ins_valid drops next cycle.
  - Any partially fetched bytes are discarded.
  - A mem_ack in the same cycle is ignored.
- Jump in the same cycle as a VALID handshake: the instruction counts as consumed; jmp_addr wins over rip+3.
- Halt (hlt=1, any state):
  - Next state HALTED: mem_req=0, ins_valid=0, halted=1.
  - Only reset exits HALTED.
  - hlt has priority over jmp_en and the handshake. An instruction presented in the same cycle as hlt is not replayed.
- Wrap-around: rip=2^ADDR_W-2 fetches addresses FE, FF, 00 (for ADDR_W=8); next rip=01.
- The memory must not see mem_req drop while an access is outstanding, except via jump, halt or reset. The memory model treats a dropped req as a cancelled access.

Decomposition:
- Shared package goofy_pkg: INSTR_BYTES=3, fetch state encoding type, default ADDR_W/DATA_W constants (shared with GoofyCore and the memory model).
- No sub-module is natural. One always_ff holds state, rip and the byte registers; one combinational block drives mem_req/mem_addr/ins_valid.

Test Plan:
- Reset release, zero-wait memory holding 0x11,0x22,0x33 at 0x00..0x02, ins_ready=1 -> mem_addr 00,01,02 on cycles 0-2; cycle 3 ins_valid=1, iop=11, op0=22, op1=33, ins_rip=00; cycle 4 mem_addr=03.
- mem_ack delayed by 2 cycles per byte -> mem_addr holds each value for 3 cycles; ins_valid on cycle 9; byte values correct.
- ins_ready=0 for 5 cycles while valid -> ins_valid and outputs stable, mem_req=0; rip advances by exactly 3 after ready=1.
- jmp_en with jmp_addr=0x40 during F_A -> next cycle mem_addr=40 (F_OP); first presented instruction has ins_rip=40 and bytes from 40..42; jump coincident with a handshake -> next fetch at 40.
- RESET_VEC=0xFE -> fetch addresses FE,FF,00; ins_rip=FE; next ins_rip=01.
- hlt pulse during F_B with jmp_en=1 -> HALTED, halted=1, mem_req=0 thereafter; res=0 pulse -> fetch restarts at RESET_VEC.

Source files
------------

// File: rtl/goofy_pkg.sv
// Constants and fetch state encoding shared by GoofyCore,
// the fetch stage and the memory model.
package goofy_pkg;

    localparam int GOOFY_ADDR_W = 8;
    localparam int GOOFY_DATA_W = 8;
    localparam int INSTR_BYTES  = 3;

    typedef enum logic [2:0] {
        F_OP   = 3'd0,
        F_A    = 3'd1,
        F_B    = 3'd2,
        VALID  = 3'd3,
        HALTED = 3'd4
    } fetch_state_e;

endpackage

// File: rtl/goofy_fetch.sv
// Instruction fetch stage: reads 3-byte instructions over a req/ack
// byte port and presents them to decode with a valid/ready handshake.
module goofy_fetch
    import goofy_pkg::*;
#(
    parameter int                ADDR_W    = GOOFY_ADDR_W,
    parameter int                DATA_W    = GOOFY_DATA_W,
    parameter logic [ADDR_W-1:0] RESET_VEC = '0
) (
    input  logic              clk,
    input  logic              res,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_data,
    output logic              ins_valid,
    input  logic              ins_ready,
    output logic [DATA_W-1:0] iop,
    output logic [DATA_W-1:0] op0,
    output logic [DATA_W-1:0] op1,
    output logic [ADDR_W-1:0] ins_rip,
    input  logic              jmp_en,
    input  logic [ADDR_W-1:0] jmp_addr,
    input  logic              hlt,
    output logic              halted
);

    localparam logic [ADDR_W-1:0] OFF_A = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] OFF_B = ADDR_W'(2);
    localparam logic [ADDR_W-1:0] STEP  = ADDR_W'(INSTR_BYTES);

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] rip_q, rip_d;
    logic [ADDR_W-1:0] ins_rip_q, ins_rip_d;
    logic [DATA_W-1:0] iop_q, iop_d;
    logic [DATA_W-1:0] op0_q, op0_d;
    logic [DATA_W-1:0] op1_q, op1_d;

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            state_q   <= F_OP;
            rip_q     <= RESET_VEC;
            ins_rip_q <= '0;
            iop_q     <= '0;
            op0_q     <= '0;
            op1_q     <= '0;
        end else begin
            state_q   <= state_d;
            rip_q     <= rip_d;
            ins_rip_q <= ins_rip_d;
            iop_q     <= iop_d;
            op0_q     <= op0_d;
            op1_q     <= op1_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        rip_d     = rip_q;
        ins_rip_d = ins_rip_q;
        iop_d     = iop_q;
        op0_d     = op0_q;
        op1_d     = op1_q;
        mem_req   = 1'b0;
        mem_addr  = rip_q;
        ins_valid = 1'b0;

        unique case (state_q)
            F_OP: begin
                mem_req  = 1'b1;
                mem_addr = rip_q;
                if (mem_ack) begin
                    iop_d   = mem_data;
                    state_d = F_A;
                end
            end
            F_A: begin
                mem_req  = 1'b1;
                mem_addr = rip_q + OFF_A;
                if (mem_ack) begin
                    op0_d   = mem_data;
                    state_d = F_B;
                end
            end
            F_B: begin
                mem_req  = 1'b1;
                mem_addr = rip_q + OFF_B;
                if (mem_ack) begin
                    op1_d     = mem_data;
                    ins_rip_d = rip_q;
                    state_d   = VALID;
                end
            end
            VALID: begin
                ins_valid = 1'b1;
                if (ins_ready) begin
                    rip_d   = rip_q + STEP;
                    state_d = F_OP;
                end
            end
            HALTED: begin
                state_d = HALTED;
            end
            default: begin
                state_d = F_OP;
            end
        endcase

        // A redirect drops any bytes captured this cycle along with the fetch
        if (jmp_en && state_q != HALTED) begin
            rip_d     = jmp_addr;
            state_d   = F_OP;
            ins_rip_d = ins_rip_q;
            iop_d     = iop_q;
            op0_d     = op0_q;
            op1_d     = op1_q;
        end

        if (hlt) begin
            state_d   = HALTED;
            rip_d     = rip_q;
            ins_rip_d = ins_rip_q;
            iop_d     = iop_q;
            op0_d     = op0_q;
            op1_d     = op1_q;
        end
    end

    assign iop     = iop_q;
    assign op0     = op0_q;
    assign op1     = op1_q;
    assign ins_rip = ins_rip_q;
    assign halted  = (state_q == HALTED);

endmodule

// File: tb/tb_goofy_fetch.sv
// Directed bench for goofy_fetch: handshake timing, wait states,
// backpressure, jumps, wrap-around, halt and reset.
module tb_goofy_fetch;

    logic       clk;
    logic       res;
    logic       ins_ready;
    logic       jmp_en;
    logic [7:0] jmp_addr;
    logic       hlt;

    logic       mem_req, mem_ack, ins_valid, halted;
    logic [7:0] mem_addr, mem_data, iop, op0, op1, ins_rip;

    logic       w_req, w_valid, w_halted;
    logic [7:0] w_addr, w_data, w_iop, w_op0, w_op1, w_rip;

    logic [7:0] mem [256];
    int         delay;
    int         cnt;
    int         checks;
    int         errors;

    goofy_fetch #(.ADDR_W(8), .DATA_W(8), .RESET_VEC(8'h00)) u_dut (
        .clk(clk), .res(res),
        .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_ack(mem_ack), .mem_data(mem_data),
        .ins_valid(ins_valid), .ins_ready(ins_ready),
        .iop(iop), .op0(op0), .op1(op1), .ins_rip(ins_rip),
        .jmp_en(jmp_en), .jmp_addr(jmp_addr),
        .hlt(hlt), .halted(halted)
    );

    goofy_fetch #(.ADDR_W(8), .DATA_W(8), .RESET_VEC(8'hFE)) u_wrap (
        .clk(clk), .res(res),
        .mem_req(w_req), .mem_addr(w_addr),
        .mem_ack(w_req), .mem_data(w_data),
        .ins_valid(w_valid), .ins_ready(1'b1),
        .iop(w_iop), .op0(w_op0), .op1(w_op1), .ins_rip(w_rip),
        .jmp_en(1'b0), .jmp_addr(8'h00),
        .hlt(1'b0), .halted(w_halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // memory model: ack after 'delay' wait cycles of a held request
    always @(posedge clk) begin
        if (!res) cnt <= 0;
        else if (mem_req && !mem_ack) cnt <= cnt + 1;
        else cnt <= 0;
    end
    assign mem_ack  = mem_req && (cnt >= delay);
    assign mem_data = mem[mem_addr];
    assign w_data   = mem[w_addr];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        for (int i = 0; i < 256; i++) mem[i] = 8'(i + 8'h80);
        mem[0] = 8'h11;
        mem[1] = 8'h22;
        mem[2] = 8'h33;
        res = 1'b0;
        ins_ready = 1'b1;
        jmp_en = 1'b0;
        jmp_addr = 8'h00;
        hlt = 1'b0;
        delay = 0;

        tick();
        chk("rst_valid", 32'(ins_valid), 32'h0);
        chk("rst_halted", 32'(halted), 32'h0);
        chk("rst_iop", 32'(iop), 32'h0);
        chk("rst_op0", 32'(op0), 32'h0);
        chk("rst_op1", 32'(op1), 32'h0);
        chk("rst_rip", 32'(ins_rip), 32'h0);
        res = 1'b1;

        // zero-wait fetch, both instances
        chk("c0_req", 32'(mem_req), 32'h1);
        chk("c0_addr", 32'(mem_addr), 32'h00);
        chk("w_c0_addr", 32'(w_addr), 32'hFE);
        tick();
        chk("c1_addr", 32'(mem_addr), 32'h01);
        chk("w_c1_addr", 32'(w_addr), 32'hFF);
        tick();
        chk("c2_addr", 32'(mem_addr), 32'h02);
        chk("w_c2_addr", 32'(w_addr), 32'h00);
        tick();
        chk("c3_valid", 32'(ins_valid), 32'h1);
        chk("c3_req", 32'(mem_req), 32'h0);
        chk("c3_iop", 32'(iop), 32'h11);
        chk("c3_op0", 32'(op0), 32'h22);
        chk("c3_op1", 32'(op1), 32'h33);
        chk("c3_rip", 32'(ins_rip), 32'h00);
        chk("w_c3_valid", 32'(w_valid), 32'h1);
        chk("w_c3_rip", 32'(w_rip), 32'hFE);
        chk("w_c3_iop", 32'(w_iop), 32'h7E);
        chk("w_c3_op0", 32'(w_op0), 32'h7F);
        chk("w_c3_op1", 32'(w_op1), 32'h11);
        tick();
        chk("c4_addr", 32'(mem_addr), 32'h03);
        chk("c4_valid", 32'(ins_valid), 32'h0);
        chk("w_c4_addr", 32'(w_addr), 32'h01);
        tick();
        tick();
        tick();
        chk("c7_valid", 32'(ins_valid), 32'h1);
        chk("c7_rip", 32'(ins_rip), 32'h03);
        chk("c7_iop", 32'(iop), 32'h83);
        chk("c7_op1", 32'(op1), 32'h85);
        chk("w_c7_rip", 32'(w_rip), 32'h01);
        chk("w_c7_iop", 32'(w_iop), 32'h22);
        chk("w_c7_op1", 32'(w_op1), 32'h83);

        // two wait states per byte, then backpressure
        delay = 2;
        ins_ready = 1'b0;
        res = 1'b0;
        tick();
        res = 1'b1;
        for (int c = 0; c < 9; c++) begin
            chk($sformatf("ws_req_%0d", c), 32'(mem_req), 32'h1);
            chk($sformatf("ws_addr_%0d", c), 32'(mem_addr), 32'(c / 3));
            chk($sformatf("ws_valid_%0d", c), 32'(ins_valid), 32'h0);
            tick();
        end
        for (int c = 9; c < 14; c++) begin
            chk($sformatf("bp_valid_%0d", c), 32'(ins_valid), 32'h1);
            chk($sformatf("bp_req_%0d", c), 32'(mem_req), 32'h0);
            chk($sformatf("bp_iop_%0d", c), 32'(iop), 32'h11);
            chk($sformatf("bp_op0_%0d", c), 32'(op0), 32'h22);
            chk($sformatf("bp_op1_%0d", c), 32'(op1), 32'h33);
            chk($sformatf("bp_rip_%0d", c), 32'(ins_rip), 32'h00);
            tick();
        end
        chk("c14_valid", 32'(ins_valid), 32'h1);
        ins_ready = 1'b1;
        delay = 0;
        tick();
        chk("c15_addr", 32'(mem_addr), 32'h03);
        chk("c15_valid", 32'(ins_valid), 32'h0);

        // jump during F_A with a coincident ack
        tick();
        chk("c16_addr", 32'(mem_addr), 32'h04);
        jmp_en = 1'b1;
        jmp_addr = 8'h40;
        tick();
        jmp_en = 1'b0;
        chk("jmp_req", 32'(mem_req), 32'h1);
        chk("jmp_addr", 32'(mem_addr), 32'h40);
        tick();
        chk("jmp_a", 32'(mem_addr), 32'h41);
        tick();
        chk("jmp_b", 32'(mem_addr), 32'h42);
        tick();
        chk("jmp_valid", 32'(ins_valid), 32'h1);
        chk("jmp_rip", 32'(ins_rip), 32'h40);
        chk("jmp_iop", 32'(iop), 32'hC0);
        chk("jmp_op0", 32'(op0), 32'hC1);
        chk("jmp_op1", 32'(op1), 32'hC2);

        // jump coincident with a handshake wins over rip+3
        jmp_en = 1'b1;
        jmp_addr = 8'h40;
        tick();
        jmp_en = 1'b0;
        chk("hs_jmp_valid", 32'(ins_valid), 32'h0);
        chk("hs_jmp_addr", 32'(mem_addr), 32'h40);

        // halt during F_B beats a jump
        tick();
        tick();
        chk("pre_hlt_addr", 32'(mem_addr), 32'h42);
        hlt = 1'b1;
        jmp_en = 1'b1;
        jmp_addr = 8'h10;
        tick();
        hlt = 1'b0;
        chk("hlt_halted", 32'(halted), 32'h1);
        chk("hlt_req", 32'(mem_req), 32'h0);
        chk("hlt_valid", 32'(ins_valid), 32'h0);
        for (int c = 0; c < 3; c++) begin
            tick();
            chk($sformatf("hold_halted_%0d", c), 32'(halted), 32'h1);
            chk($sformatf("hold_req_%0d", c), 32'(mem_req), 32'h0);
            chk($sformatf("hold_valid_%0d", c), 32'(ins_valid), 32'h0);
        end
        jmp_en = 1'b0;

        // asynchronous reset leaves HALTED
        #2;
        res = 1'b0;
        #1;
        chk("ar_halted", 32'(halted), 32'h0);
        chk("ar_req", 32'(mem_req), 32'h1);
        chk("ar_addr", 32'(mem_addr), 32'h00);
        tick();
        res = 1'b1;
        chk("rs_addr0", 32'(mem_addr), 32'h00);
        tick();
        chk("rs_addr1", 32'(mem_addr), 32'h01);
        tick();
        tick();
        chk("rs_valid", 32'(ins_valid), 32'h1);
        chk("rs_iop", 32'(iop), 32'h11);
        chk("rs_rip", 32'(ins_rip), 32'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
